logical_shift_unit: RTL and testbench

32-bit logical shift unit that computes a left and a right logical shift of one operand by a 5-bit amount in parallel. It is the shift datapath of the single-cycle processor's execution stage. Outputs are registered, giving a one-cycle pipeline stage. It is built from two independent 5-stage barrel shifters: full_left_logical_shifter and full_right_logical_shifter.

---
 rtl/logical_shift_unit.sv | 87 ++++++++
 tb/tb_logical_shift_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/logical_shift_unit.sv
// 32-bit logical shift unit: left and right barrel shifts of A by B, computed in
// parallel and registered as a single pipeline stage.

module full_right_logical_shifter (
    input  logic [31:0] a,
    input  logic [4:0]  b,
    output logic [31:0] y
);
    logic [31:0] s1, s2, s3, s4;

    // Stage k shifts by 2^k when b[k] is set; vacated MSBs are zero-filled.
    assign s1 = b[0] ? {1'b0,  a[31:1]}  : a;
    assign s2 = b[1] ? {2'b0,  s1[31:2]} : s1;
    assign s3 = b[2] ? {4'b0,  s2[31:4]} : s2;
    assign s4 = b[3] ? {8'b0,  s3[31:8]} : s3;
    assign y  = b[4] ? {16'b0, s4[31:16]} : s4;
endmodule

module full_left_logical_shifter (
    input  logic [31:0] a,
    input  logic [4:0]  b,
    output logic [31:0] y
);
    logic [31:0] s1, s2, s3, s4;

    // Mirror image of the right shifter; vacated LSBs are zero-filled.
    assign s1 = b[0] ? {a[30:0],  1'b0}  : a;
    assign s2 = b[1] ? {s1[29:0], 2'b0}  : s1;
    assign s3 = b[2] ? {s2[27:0], 4'b0}  : s2;
    assign s4 = b[3] ? {s3[23:0], 8'b0}  : s3;
    assign y  = b[4] ? {s4[15:0], 16'b0} : s4;
endmodule

module logical_shift_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] A,
    input  logic [4:0]  B,
    output logic [31:0] res_right,
    output logic [31:0] res_left,
    output logic        valid
);
    logic [31:0] shr, shl;
    logic [31:0] res_right_d, res_right_q;
    logic [31:0] res_left_d,  res_left_q;
    logic        valid_d,     valid_q;

    full_right_logical_shifter u_shr (
        .a (A),
        .b (B),
        .y (shr)
    );

    full_left_logical_shifter u_shl (
        .a (A),
        .b (B),
        .y (shl)
    );

    // Results hold while en is low; valid flags only the cycle after a capture.
    always_comb begin
        res_right_d = res_right_q;
        res_left_d  = res_left_q;
        valid_d     = en;
        if (en) begin
            res_right_d = shr;
            res_left_d  = shl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_right_q <= 32'h0;
            res_left_q  <= 32'h0;
            valid_q     <= 1'b0;
        end else begin
            res_right_q <= res_right_d;
            res_left_q  <= res_left_d;
            valid_q     <= valid_d;
        end
    end

    assign res_right = res_right_q;
    assign res_left  = res_left_q;
    assign valid     = valid_q;
endmodule

// File: tb/tb_logical_shift_unit.sv
// Scoreboard bench for logical_shift_unit: the driver queues expected results,
// a negedge monitor pops and compares whenever valid is high and checks hold otherwise.

module tb_logical_shift_unit;
    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] A;
    logic [4:0]  B;
    logic [31:0] res_right;
    logic [31:0] res_left;
    logic        valid;

    logic [63:0] exp_q[$];
    logic [31:0] hold_r, hold_l;
    int          checks;
    int          errors;

    logical_shift_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .A         (A),
        .B         (B),
        .res_right (res_right),
        .res_left  (res_left),
        .valid     (valid)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model straight from the bit-index definition.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [4:0] b);
        logic [31:0] r, l;
        int          sh;
        sh = int'(b);
        for (int i = 0; i < 32; i++) begin
            r[i] = (i + sh <= 31) ? a[i + sh] : 1'b0;
            l[i] = (i >= sh) ? a[i - sh] : 1'b0;
        end
        return {r, l};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic op_exp(input logic [31:0] a, input logic [4:0] b,
                          input logic [31:0] er, input logic [31:0] el);
        @(negedge clk);
        en = 1'b1;
        A  = a;
        B  = b;
        exp_q.push_back({er, el});
    endtask

    task automatic op(input logic [31:0] a, input logic [4:0] b);
        logic [63:0] m;
        m = model(a, b);
        op_exp(a, b, m[63:32], m[31:0]);
    endtask

    task automatic idle();
        @(negedge clk);
        en = 1'b0;
        A  = $urandom;
        B  = 5'($urandom_range(0, 31));
    endtask

    // monitor / scoreboard
    initial begin
        logic [63:0] e;
        hold_r = 32'h0;
        hold_l = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("reset_right", res_right, 32'h0);
                chk("reset_left", res_left, 32'h0);
                chk("reset_valid", {31'b0, valid}, 32'h0);
                hold_r = 32'h0;
                hold_l = 32'h0;
            end else if (valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got valid=1 expected no result at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_right", res_right, e[63:32]);
                    chk("res_left", res_left, e[31:0]);
                    hold_r = e[63:32];
                    hold_l = e[31:0];
                end
            end else begin
                chk("hold_right", res_right, hold_r);
                chk("hold_left", res_left, hold_l);
            end
        end
    end

    // stimulus
    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        en     = 1'b0;
        A      = 32'h0;
        B      = 5'd0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) idle();

        for (int b = 0; b < 32; b++) begin
            if (b == 0)       op_exp(32'h55555555, 5'(b), 32'h55555555, 32'h55555555);
            else if (b == 1)  op_exp(32'h55555555, 5'(b), 32'h2AAAAAAA, 32'hAAAAAAAA);
            else if (b == 31) op_exp(32'h55555555, 5'(b), 32'h00000000, 32'h80000000);
            else              op(32'h55555555, 5'(b));
        end
        for (int b = 0; b < 32; b++) begin
            if (b == 4)       op_exp(32'hAAAAAAAA, 5'(b), 32'h0AAAAAAA, 32'hAAAAAAA0);
            else if (b == 31) op_exp(32'hAAAAAAAA, 5'(b), 32'h00000001, 32'h00000000);
            else              op(32'hAAAAAAAA, 5'(b));
        end
        idle();

        for (int j = 0; j < 32; j++)
            for (int b = 0; b < 32; b++)
                op(32'h1 << j, 5'(b));

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) idle();
            else op($urandom, 5'($urandom_range(0, 31)));
        end

        // hold after capture, valid drops one cycle later
        op_exp(32'hFFFFFFFF, 5'd8, 32'h00FFFFFF, 32'hFFFFFF00);
        repeat (3) idle();

        // asynchronous reset mid-cycle, checked immediately
        @(posedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_reset_right", res_right, 32'h0);
        chk("async_reset_left", res_left, 32'h0);
        chk("async_reset_valid", {31'b0, valid}, 32'h0);
        idle();
        #2 rst_n = 1'b1;
        repeat (2) idle();

        // reset while streaming with B = 3; in-flight result must be dropped
        for (int n = 0; n < 4; n++) op($urandom | 32'h1, 5'd3);
        op(32'hDEADBEEF, 5'd3);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("stream_reset_right", res_right, 32'h0);
        chk("stream_reset_left", res_left, 32'h0);
        repeat (2) @(negedge clk);
        en = 1'b0;
        #2 rst_n = 1'b1;
        repeat (3) idle();

        for (int n = 0; n < 20; n++) op($urandom, 5'($urandom_range(0, 31)));
        repeat (3) idle();

        chk("leftover_results", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
